// File: rtl/cc_stack_unit_if.sv
// cc_stack_unit_if: request/response bundle between the control path and the CC stack unit.
//   ld_cc, bus, push, pop, ld_ben, ir_nzp : requests driven by the master (control FSM / datapath)
//   cc, ben, depth, full, empty, err      : status returned by the slave (cc_stack_unit)
interface cc_stack_unit_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);
    logic             ld_cc;
    logic [WIDTH-1:0] bus;
    logic             push;
    logic             pop;
    logic             ld_ben;
    logic [2:0]       ir_nzp;
    logic [2:0]       cc;
    logic             ben;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             err;
    modport master (
        output ld_cc, bus, push, pop, ld_ben, ir_nzp,
        input  cc, ben, depth, full, empty, err
    );
    modport slave (
        input  ld_cc, bus, push, pop, ld_ben, ir_nzp,
        output cc, ben, depth, full, empty, err
    );
endinterface

// File: rtl/cc_stack_unit.sv
// cc_stack_unit: NZP condition-code register with registered BEN and a LIFO of saved CC values.
//   clk    : rising-edge clock
//   reset_ : synchronous active-high reset
//   sif    : slave side of cc_stack_unit_if
//            ld_cc/bus load cc from the bus classification, push/pop save/restore cc,
//            ld_ben/ir_nzp latch ben; cc, ben, depth, err are registered, full/empty decode depth
module cc_stack_unit #(
    parameter int         WIDTH    = 16,
    parameter int         DEPTH    = 4,
    parameter bit         SIGNED   = 1'b1,
    parameter logic [2:0] RESET_CC = 3'b010
) (
    input logic             clk,
    input logic             reset_,
    cc_stack_unit_if.slave  sif
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [2:0]    r_lifo [DEPTH];
    logic [2:0]    r_cc;
    logic          r_ben;
    logic [DW-1:0] r_depth;
    logic          r_err;
    logic [2:0]    w_class;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_err;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    assign w_class   = (SIGNED && sif.bus[WIDTH-1]) ? 3'b100 : (sif.bus == '0) ? 3'b010 : 3'b001;
    assign w_full    = r_depth == DW'(DEPTH);
    assign w_empty   = r_depth == '0;
    // push and pop together is illegal, so each legal operation excludes the other
    assign w_push_ok = sif.push && !sif.pop && !w_full;
    assign w_pop_ok  = sif.pop && !sif.push && !w_empty;
    assign w_err     = (sif.push && (sif.pop || w_full)) || (sif.pop && w_empty);
    assign w_wr_idx  = AW'(r_depth);
    assign w_rd_idx  = AW'(r_depth - 1'b1);
    // saved values need no reset: entries above depth are never read
    always_ff @(posedge clk) begin
        if (w_push_ok) r_lifo[w_wr_idx] <= r_cc;
    end
    always_ff @(posedge clk) begin
        if (reset_) begin
            r_cc    <= RESET_CC;
            r_ben   <= 1'b0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cc    <= w_pop_ok ? r_lifo[w_rd_idx] : sif.ld_cc ? w_class : r_cc;
            // ben samples the pre-edge cc, so a same-edge ld_cc/pop is not seen
            r_ben   <= sif.ld_ben ? |(sif.ir_nzp & r_cc) : r_ben;
            r_depth <= w_push_ok ? r_depth + 1'b1 : w_pop_ok ? r_depth - 1'b1 : r_depth;
            r_err   <= w_err;
        end
    end
    assign sif.cc    = r_cc;
    assign sif.ben   = r_ben;
    assign sif.depth = r_depth;
    assign sif.full  = w_full;
    assign sif.empty = w_empty;
    assign sif.err   = r_err;
endmodule

// File: tb/tb_cc_stack_unit.sv
// tb_cc_stack_unit: vector table plus randomized run of signed and unsigned cc_stack_unit against a queue model.
module tb_cc_stack_unit;
    localparam int DEPTH = 4;
    typedef struct {
        logic        rs;
        logic        lc;
        logic [15:0] b;
        logic        ps;
        logic        pp;
        logic        lb;
        logic [2:0]  nz;
        logic [2:0]  cs;
        logic [2:0]  cu;
        logic        bs;
        int          dp;
        logic        er;
    } vec_t;
    logic clk = 1'b0;
    logic reset_;
    int   n_chk = 0;
    int   n_fail = 0;
    string tag;
    logic [2:0] m_cc [2];
    logic       m_ben [2];
    logic       m_err;
    logic [5:0] q [$];
    vec_t tv [30];
    cc_stack_unit_if #(.WIDTH(16), .DEPTH(DEPTH)) if_s ();
    cc_stack_unit_if #(.WIDTH(16), .DEPTH(DEPTH)) if_u ();
    cc_stack_unit #(.WIDTH(16), .DEPTH(DEPTH), .SIGNED(1'b1), .RESET_CC(3'b010)) u_s (
        .clk(clk), .reset_(reset_), .sif(if_s)
    );
    cc_stack_unit #(.WIDTH(16), .DEPTH(DEPTH), .SIGNED(1'b0), .RESET_CC(3'b010)) u_u (
        .clk(clk), .reset_(reset_), .sif(if_u)
    );
    always #5 clk = ~clk;
    function automatic logic [2:0] cls(input bit sg, input logic [15:0] b);
        if (sg && $signed(b) < 0) return 3'b100;
        return (b == 16'd0) ? 3'b010 : 3'b001;
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask
    task automatic step(input logic rs, input logic lc, input logic [15:0] b, input logic ps,
                        input logic pp, input logic lb, input logic [2:0] nz);
        bit perr;
        bit popd;
        logic [2:0] old [2];
        logic [5:0] top;
        reset_ = rs;
        if_s.ld_cc = lc; if_s.bus = b; if_s.push = ps; if_s.pop = pp; if_s.ld_ben = lb; if_s.ir_nzp = nz;
        if_u.ld_cc = lc; if_u.bus = b; if_u.push = ps; if_u.pop = pp; if_u.ld_ben = lb; if_u.ir_nzp = nz;
        @(posedge clk);
        if (rs) begin
            m_cc[0] = 3'b010; m_cc[1] = 3'b010;
            m_ben[0] = 1'b0; m_ben[1] = 1'b0;
            m_err = 1'b0;
            q.delete();
        end else begin
            perr = (ps && (pp || q.size() == DEPTH)) || (pp && q.size() == 0);
            old = m_cc;
            popd = 1'b0;
            top = '0;
            for (int k = 0; k < 2; k++) if (lb) m_ben[k] = |(nz & old[k]);
            if (!perr && pp) begin
                top = q.pop_back();
                popd = 1'b1;
            end
            if (!perr && ps) q.push_back({old[0], old[1]});
            m_cc[0] = popd ? top[5:3] : lc ? cls(1'b1, b) : old[0];
            m_cc[1] = popd ? top[2:0] : lc ? cls(1'b0, b) : old[1];
            m_err = perr;
        end
        #1;
        chk("cc_s", int'(if_s.cc), int'(m_cc[0]));
        chk("cc_u", int'(if_u.cc), int'(m_cc[1]));
        chk("ben_s", int'(if_s.ben), int'(m_ben[0]));
        chk("ben_u", int'(if_u.ben), int'(m_ben[1]));
        chk("depth_s", int'(if_s.depth), q.size());
        chk("depth_u", int'(if_u.depth), q.size());
        chk("full_s", int'(if_s.full), int'(q.size() == DEPTH));
        chk("empty_s", int'(if_s.empty), int'(q.size() == 0));
        chk("full_u", int'(if_u.full), int'(q.size() == DEPTH));
        chk("empty_u", int'(if_u.empty), int'(q.size() == 0));
        chk("err_s", int'(if_s.err), int'(m_err));
        chk("err_u", int'(if_u.err), int'(m_err));
    endtask
    initial begin
        tv = '{
            '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 3'b010, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 3'b010, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'hFFF0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b010, 3'b010, 1'b0, 1, 1'b0},
            '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001, 1'b0, 2, 1'b0},
            '{1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 3, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 4, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 4, 1'b1},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 4, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 3, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 3'b001, 1'b0, 2, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 3'b010, 1'b0, 1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 0, 1'b1},
            '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 3'b010, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 3'b011, 3'b100, 3'b001, 1'b1, 0, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'b011, 3'b100, 3'b001, 1'b0, 0, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 2, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 2, 1'b1},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'b100, 3'b100, 3'b001, 1'b1, 3, 1'b0},
            '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 3'b000, 3'b010, 3'b010, 1'b0, 0, 1'b0},
            '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 3'b001, 1'b0, 0, 1'b1}
        };
        for (int i = 0; i < 30; i++) begin
            tag = $sformatf("vec%0d", i);
            step(tv[i].rs, tv[i].lc, tv[i].b, tv[i].ps, tv[i].pp, tv[i].lb, tv[i].nz);
            chk("tv_cc_s", int'(if_s.cc), int'(tv[i].cs));
            chk("tv_cc_u", int'(if_u.cc), int'(tv[i].cu));
            chk("tv_ben_s", int'(if_s.ben), int'(tv[i].bs));
            chk("tv_depth", int'(if_s.depth), tv[i].dp);
            chk("tv_err", int'(if_s.err), int'(tv[i].er));
        end
        for (int i = 0; i < 400; i++) begin
            tag = $sformatf("rnd%0d", i);
            step($urandom_range(0, 63) == 0,
                 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 1'($urandom),
                 3'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cc_stack_unit.md
Name: cc_stack_unit

Overview:
- Parametrised successor to the LC-3 condition-code register: holds the NZP flags derived from the datapath bus.
- Adds a configurable-width bus, a signed/unsigned classification mode, and a registered branch-enable (BEN) evaluator.
- Adds a small LIFO of saved CC values so interrupt entry/RTI can save and restore the flags in hardware.
- Sits between the bus driver mux and the control FSM, feeding the BEN and CC outputs to the FSM and the PSR logic.

Parameters:
- WIDTH, 16, bus width in bits (>=2).
- DEPTH, 4, number of saved-CC entries in the LIFO (>=1).
- SIGNED, 1, 1 = bus is two's complement (MSB set -> N); 0 = unsigned (N never set).
- RESET_CC, 3'b010, CC value loaded on reset (N,Z,P order, MSB = N).

Ports:
- clk  in  1  rising-edge clock
- reset_  in  1  synchronous reset, active-high
- ld_cc  in  1  load CC from classification of bus
- bus  in  WIDTH  datapath bus value
- push  in  1  save current CC onto LIFO
- pop  in  1  restore CC from LIFO top
- ld_ben  in  1  latch branch-enable
- ir_nzp  in  3  branch condition mask (IR[11:9])
- cc  out  3  current NZP flags
- ben  out  1  registered branch enable
- depth  out  $clog2(DEPTH+1)  number of occupied LIFO entries
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset (reset_ = 1 at a rising edge) overrides everything and applies on that edge:
  - cc = RESET_CC, ben = 0, depth = 0, err = 0.
  - LIFO contents are don't-care.
- Classification (combinational, from bus):
  - SIGNED = 1: bus[WIDTH-1] = 1 -> 100; bus == 0 -> 010; else -> 001.
  - SIGNED = 0: bus == 0 -> 010; else -> 001.
- cc update, evaluated per rising edge, first match wins:
  - pop legal: cc = LIFO top; depth decrements.
  - ld_cc: cc = classification.
  - otherwise cc holds.
  - A legal pop beats ld_cc in the same cycle.
- push legal (not full, no pop): LIFO[depth] = cc as it was before this edge; depth increments.
  - push and ld_cc together: the saved value is the old cc; cc takes the new classification.
- Illegal requests: no LIFO, depth or cc change from the request itself; err = 1 for exactly one cycle, otherwise err = 0.
  - push while full.
  - pop while empty.
  - push and pop together.
  - On push while full or push+pop, ld_cc still applies if asserted.
  - On pop while empty, ld_cc still applies if asserted.
- BEN:
  - When ld_ben = 1, ben = |(ir_nzp & cc_old), using the pre-edge cc even if ld_cc or pop updates cc on the same edge.
  - Otherwise ben holds.
- Latency:
  - cc, ben, depth, full, empty and err all change one cycle after the request edge.
  - full and empty are decoded from registered depth.
- Outputs are fully registered except full and empty (decoded from depth); the classification path is combinational only into the cc register.

Test Plan:
1. Reset, then WIDTH = 16, SIGNED = 1, ld_cc with bus = 16'h8000 -> cc = 100; bus = 16'h0000 -> 010; bus = 16'h7FFF -> 001; ld_cc = 0 with bus changing -> cc holds.
2. SIGNED = 0 instance, ld_cc with bus = 16'hFFFF -> cc = 001, with bus = 0 -> 010; after reset, cc = RESET_CC = 010.
3. cc = 001; push and ld_cc with bus = 16'hFFF0 on the same edge -> cc = 100, depth = 1. Next cycle pop -> cc = 001, depth = 0, empty = 1.
4. Four pushes with cc = 100, 010, 001, 100 -> depth = 4, full = 1. Fifth push -> err pulses 1 for one cycle, depth stays 4. Four pops -> cc = 100, 001, 010, 100 in order. Further pop -> err = 1, cc unchanged.
5. cc = 010, ir_nzp = 011, ld_ben together with ld_cc (bus = 16'hFFFF) -> ben = 1 (uses old Z) while cc becomes 100. Next ld_ben with ir_nzp = 011 -> ben = 0.
6. push and pop asserted together with depth = 2 -> err = 1, depth = 2, cc unchanged. reset_ asserted mid-sequence with depth = 3 -> depth = 0, ben = 0, cc = 010 on the next edge.
